// File: rtl/cla32_seq_pkg.sv
// Shared definitions for the sequential wide adder: state encoding, word width,
// and the 4-bit look-ahead helper functions used inside cla32.
package cla32_seq_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Carries into positions 1..3 of a 4-wide look-ahead block, given block carry-in.
    function automatic logic [2:0] la4_carry(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c0
    );
        logic c1;
        logic c2;
        logic c3;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return {c3, c2, c1};
    endfunction

    function automatic logic la4_grp_g(
        input logic [3:0] g,
        input logic [3:0] p
    );
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic la4_grp_p(
        input logic [3:0] p
    );
        return &p;
    endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry look-ahead adder: 4-bit groups, 16-bit sections, and a
// two-section top level. Purely combinational.
module cla32
    import cla32_seq_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [7:0]  grp_c;
    logic [1:0]  sec_g;
    logic [1:0]  sec_p;
    logic [1:0]  sec_c;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        sec_g = '0;
        sec_p = '0;
        sec_c = '0;

        for (int j = 0; j < 8; j++) begin
            grp_g[j] = la4_grp_g(g[4*j +: 4], p[4*j +: 4]);
            grp_p[j] = la4_grp_p(p[4*j +: 4]);
        end

        for (int k = 0; k < 2; k++) begin
            sec_g[k] = la4_grp_g(grp_g[4*k +: 4], grp_p[4*k +: 4]);
            sec_p[k] = la4_grp_p(grp_p[4*k +: 4]);
        end

        // Top level resolves both section carries directly from ci.
        sec_c[0] = ci;
        sec_c[1] = sec_g[0] | (sec_p[0] & ci);
        co       = sec_g[1] | (sec_p[1] & sec_g[0]) | (sec_p[1] & sec_p[0] & ci);

        for (int k = 0; k < 2; k++) begin
            grp_c[4*k]         = sec_c[k];
            grp_c[4*k+1 +: 3]  = la4_carry(grp_g[4*k +: 4], grp_p[4*k +: 4], sec_c[k]);
        end

        for (int j = 0; j < 8; j++) begin
            c[4*j]        = grp_c[j];
            c[4*j+1 +: 3] = la4_carry(g[4*j +: 4], p[4*j +: 4], grp_c[j]);
        end

        s = p ^ c;
    end

endmodule

// File: rtl/cla32_seq_adder.sv
// Multi-cycle WORDS x 32-bit adder that time-shares one cla32, LS word first.
// Optional subtract port enabled by defining CLA32_SEQ_SUB_EN.
module cla32_seq_adder
    import cla32_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    ci,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
`ifdef CLA32_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [WORD_W*WORDS-1:0] s,
    output logic                    co
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          carry_q, carry_d;
    logic                          co_q, co_d;
    logic [WORDS-1:0][WORD_W-1:0]  a_q, a_d;
    logic [WORDS-1:0][WORD_W-1:0]  b_q, b_d;
    logic [WORDS-1:0][WORD_W-1:0]  s_q, s_d;

    logic [WORD_W-1:0]             add_a;
    logic [WORD_W-1:0]             add_b;
    logic [WORD_W-1:0]             add_s;
    logic                          add_co;

    cla32 u_cla32 (
        .a  (add_a),
        .b  (add_b),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        co_d    = co_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        add_a   = a_q[idx_q];
        add_b   = b_q[idx_q];

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
`ifdef CLA32_SEQ_SUB_EN
                    // Subtract as a + ~b + 1; ci has no meaning here.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : ci;
`else
                    b_d     = b;
                    carry_d = ci;
`endif
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                s_d[idx_q] = add_s;
                carry_d    = add_co;
                idx_d      = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    co_d    = add_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_cla32_seq_adder.sv
// Self-checking bench for cla32_seq_adder (WORDS=4): randomized operations
// against a wide-arithmetic model, plus hand-computed directed cases.
module tb_cla32_seq_adder;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;
`ifdef CLA32_SEQ_SUB_EN
    localparam bit SUB_BUILD = 1'b1;
`else
    localparam bit SUB_BUILD = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         start_i;
    logic         ci_i;
    logic         sub_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] s_o;
    logic         co_o;

    int n_cmp = 0;
    int n_err = 0;

    cla32_seq_adder #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start_i),
        .ci    (ci_i),
        .a     (a_i),
        .b     (b_i),
`ifdef CLA32_SEQ_SUB_EN
        .sub   (sub_i),
`endif
        .busy  (busy_o),
        .done  (done_o),
        .s     (s_o),
        .co    (co_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c, input logic sb);
        logic [W:0] r;
        if (sb) r = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        else    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        return r;
    endfunction

    // Behavioural model: remaining cycles of the current operation and expected results.
    int           cnt;
    logic [W-1:0] exp_s;
    logic         exp_co;
    logic         sub_eff;

    assign sub_eff = SUB_BUILD ? sub_i : 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 0;
            exp_s  <= '0;
            exp_co <= 1'b0;
        end else if (cnt == 0) begin
            if (start_i) begin
                cnt             <= WORDS + 1;
                {exp_co, exp_s} <= model_sum(a_i, b_i, ci_i, sub_eff);
            end
        end else begin
            cnt <= cnt - 1;
        end
    end

    always @(negedge clk) begin
        check("busy", W'(busy_o), W'(cnt != 0));
        check("done", W'(done_o), W'(cnt == 1));
        if (cnt <= 1) begin
            check("s", s_o, exp_s);
            check("co", W'(co_o), W'(exp_co));
        end
    end

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic sb,
                          input logic [W-1:0] want_s, input logic want_co);
        int n;
        @(negedge clk);
        a_i = a; b_i = b; ci_i = c; sub_i = sb; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 1;
        while (!done_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, W'(n), W'(WORDS + 1));
        check({nm, "_s"}, s_o, want_s);
        check({nm, "_co"}, W'(co_o), W'(want_co));
    endtask

    initial begin
        int           n;
        int           dones;
        int           hold;
        logic [W-1:0] ones;
        ones    = '1;
        reset   = 1'b1;
        start_i = 1'b0;
        ci_i    = 1'b0;
        sub_i   = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", W'(busy_o), '0);
        check("reset_s", s_o, '0);
        reset = 1'b0;

        run_op("zero", '0, '0, 1'b0, 1'b0, '0, 1'b0);
        run_op("ripple", ones, '0, 1'b1, 1'b0, '0, 1'b1);
        run_op("alt_ci0", {4{32'h0000FFFF}}, {4{32'hFFFF0000}}, 1'b0, 1'b0, ones, 1'b0);
        run_op("alt_ci1", {4{32'h0000FFFF}}, {4{32'hFFFF0000}}, 1'b1, 1'b0, '0, 1'b1);

        // Start kept asserted with changing operands through the whole operation.
        @(negedge clk);
        a_i = {4{32'h12345678}}; b_i = {4{32'h35315986}}; ci_i = 1'b0; sub_i = 1'b0;
        start_i = 1'b1;
        dones = 0;
        for (int i = 1; i <= WORDS + 1; i++) begin
            @(negedge clk);
            if (done_o) dones++;
            a_i = {$urandom, $urandom, $urandom, $urandom};
            b_i = {$urandom, $urandom, $urandom, $urandom};
            ci_i = 1'($urandom);
        end
        check("busyprot_s", s_o, {4{32'h4765AFFE}});
        check("busyprot_co", W'(co_o), '0);
        @(negedge clk);
        start_i = 1'b0;
        if (done_o) dones++;
        @(negedge clk);
        if (done_o) dones++;
        check("busyprot_dones", W'(dones), W'(1));
        check("busyprot_idle", W'(busy_o), '0);

        // Asynchronous reset in cycle 2 of an operation, checked between clock edges.
        @(negedge clk);
        a_i = ones; b_i = ones; ci_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", W'(busy_o), '0);
        check("arst_done", W'(done_o), '0);
        check("arst_s", s_o, '0);
        check("arst_co", W'(co_o), '0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("arst_no_done", W'(dones), '0);
        run_op("one_plus_one", W'(1), W'(1), 1'b0, 1'b0, W'(2), 1'b0);
`ifdef CLA32_SEQ_SUB_EN
        run_op("sub_5_7", W'(5), W'(7), 1'b0, 1'b1, ones - W'(1), 1'b0);
        run_op("sub_7_5", W'(7), W'(5), 1'b1, 1'b1, W'(2), 1'b1);
`endif

        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            case ($urandom_range(0, 5))
                0:       a_i = ones;
                1:       a_i = '0;
                default: a_i = {$urandom, $urandom, $urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0:       b_i = ones;
                1:       b_i = '0;
                default: b_i = {$urandom, $urandom, $urandom, $urandom};
            endcase
            ci_i    = 1'($urandom);
            sub_i   = 1'($urandom);
            start_i = 1'b1;
            hold = $urandom_range(0, 2);
            repeat (hold + 1) begin
                @(negedge clk);
                a_i = {$urandom, $urandom, $urandom, $urandom};
                b_i = {$urandom, $urandom, $urandom, $urandom};
            end
            start_i = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                #3 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                n = 0;
                while (!done_o && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("rand_done_timeout", W'(n < 20), W'(1));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
